batch_xfer_sequencer: RTL and testbench

BATCH_XFER_SEQUENCER -- requirements
Module: batch_xfer_sequencer

---
 rtl/batch_xfer_sequencer_pkg.sv | 29 ++
 rtl/xfer_side_counter.sv | 69 ++++++
 rtl/batch_xfer_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_batch_xfer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_xfer_sequencer_pkg.sv
// Shared encodings for the batch transfer sequencer: command ops, result status
// and the sequencing FSM states.
package batch_xfer_sequencer_pkg;

  localparam logic [1:0] OP_RSVD   = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_RD     = 2'b10;
  localparam logic [1:0] OP_DUPLEX = 2'b11;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_INVALID = 2'b01;
  localparam logic [1:0] STAT_ABORTED = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // A side's bank range must be ordered, inside the bank array and non-empty.
  function automatic logic side_cfg_ok(input int unsigned first,
                                       input int unsigned last,
                                       input int unsigned banks,
                                       input logic        count_nz);
    return (first <= last) && (last < banks) && count_nz;
  endfunction

endpackage

// File: rtl/xfer_side_counter.sv
// Bank index and beat counter for one transfer side; walks first..last banks,
// count beats each, switching banks without a bubble.
module xfer_side_counter #(
  parameter int BANK_W = 4,
  parameter int ADDR_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_load,
  input  logic              i_run,
  input  logic              i_step,
  input  logic [BANK_W-1:0] i_bank_first,
  input  logic [BANK_W-1:0] i_bank_last,
  input  logic [ADDR_W-1:0] i_count,
  output logic [BANK_W-1:0] o_bank,
  output logic [ADDR_W-1:0] o_beat_idx,
  output logic              o_active,
  output logic              o_done
);

  localparam logic [BANK_W-1:0] BANK_ONE = BANK_W'(32'd1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);

  logic [BANK_W-1:0] r_bank;
  logic [ADDR_W-1:0] r_idx;
  logic              r_finished;
  logic              w_beat;
  logic              w_idx_last;
  logic              w_bank_last;

  assign w_beat      = o_active && i_step;
  assign w_idx_last  = (r_idx == (i_count - ADDR_ONE));
  assign w_bank_last = (r_bank == i_bank_last);

  assign o_bank     = r_bank;
  assign o_beat_idx = r_idx;
  assign o_active   = i_run && !r_finished;
  // Finishing counts as done so the FSM leaves RUN right after the last beat.
  assign o_done     = r_finished || (w_beat && w_idx_last && w_bank_last);

  // Bank/beat progression.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_bank     <= {BANK_W{1'b0}};
      r_idx      <= {ADDR_W{1'b0}};
      r_finished <= 1'b0;
    end else if (i_load) begin
      r_bank     <= i_bank_first;
      r_idx      <= {ADDR_W{1'b0}};
      r_finished <= 1'b0;
    end else if (w_beat) begin
      if (w_idx_last) begin
        if (w_bank_last) begin
          r_finished <= 1'b1;
        end else begin
          r_bank <= r_bank + BANK_ONE;
          r_idx  <= {ADDR_W{1'b0}};
        end
      end else begin
        r_idx <= r_idx + ADDR_ONE;
      end
    end else begin
      r_bank     <= r_bank;
      r_idx      <= r_idx;
      r_finished <= r_finished;
    end
  end

endmodule

// File: rtl/batch_xfer_sequencer.sv
// Batch transfer sequencer: takes one command, validates it, then walks write
// and/or read BRAM banks issuing enables and addresses until done or aborted.
module batch_xfer_sequencer
  import batch_xfer_sequencer_pkg::*;
#(
  parameter int WR_BANKS = 16,
  parameter int RD_BANKS = 8,
  parameter int ADDR_W   = 16,
  localparam int WB_W    = $clog2(WR_BANKS),
  localparam int RB_W    = $clog2(RD_BANKS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WB_W-1:0]   wr_bank_first,
  input  logic [WB_W-1:0]   wr_bank_last,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_count,
  input  logic [RB_W-1:0]   rd_bank_first,
  input  logic [RB_W-1:0]   rd_bank_last,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_count,
  input  logic              abort,
  input  logic              wr_beat,
  output logic              wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WB_W-1:0]   demux_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [RB_W-1:0]   mux_sel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_op;
  logic [1:0]        r_status;
  logic [WB_W-1:0]   r_wr_first;
  logic [WB_W-1:0]   r_wr_last;
  logic [ADDR_W-1:0] r_wr_base;
  logic [ADDR_W-1:0] r_wr_count;
  logic [RB_W-1:0]   r_rd_first;
  logic [RB_W-1:0]   r_rd_last;
  logic [ADDR_W-1:0] r_rd_base;
  logic [ADDR_W-1:0] r_rd_count;
  logic [RB_W-1:0]   r_mux_sel;

  logic              w_accept;
  logic              w_wr_side;
  logic              w_rd_side;
  logic              w_cfg_ok;
  logic              w_load;
  logic              w_run;
  logic              w_all_fin;
  logic [WB_W-1:0]   w_wr_bank;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_wr_active;
  logic              w_wr_done;
  logic [RB_W-1:0]   w_rd_bank;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_active;
  logic              w_rd_done;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_wr_side = (r_op == OP_WR) || (r_op == OP_DUPLEX);
  assign w_rd_side = (r_op == OP_RD) || (r_op == OP_DUPLEX);
  assign w_cfg_ok  = (r_op != OP_RSVD)
      && (!w_wr_side || side_cfg_ok(32'(r_wr_first), 32'(r_wr_last), unsigned'(WR_BANKS),
                                    (r_wr_count != {ADDR_W{1'b0}})))
      && (!w_rd_side || side_cfg_ok(32'(r_rd_first), 32'(r_rd_last), unsigned'(RD_BANKS),
                                    (r_rd_count != {ADDR_W{1'b0}})));
  assign w_load    = (r_state == ST_CHECK) && w_cfg_ok;
  assign w_run     = (r_state == ST_RUN);
  assign w_all_fin = (!w_wr_side || w_wr_done) && (!w_rd_side || w_rd_done);

  xfer_side_counter #(.BANK_W(WB_W), .ADDR_W(ADDR_W)) u_wr_side (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_load       (w_load),
    .i_run        (w_run && w_wr_side),
    .i_step       (wr_beat),
    .i_bank_first (r_wr_first),
    .i_bank_last  (r_wr_last),
    .i_count      (r_wr_count),
    .o_bank       (w_wr_bank),
    .o_beat_idx   (w_wr_idx),
    .o_active     (w_wr_active),
    .o_done       (w_wr_done)
  );

  xfer_side_counter #(.BANK_W(RB_W), .ADDR_W(ADDR_W)) u_rd_side (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_load       (w_load),
    .i_run        (w_run && w_rd_side),
    .i_step       (1'b1),
    .i_bank_first (r_rd_first),
    .i_bank_last  (r_rd_last),
    .i_count      (r_rd_count),
    .o_bank       (w_rd_bank),
    .o_beat_idx   (w_rd_idx),
    .o_active     (w_rd_active),
    .o_done       (w_rd_done)
  );

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; abort only matters while running.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_accept ? ST_CHECK : ST_IDLE;
      ST_CHECK: w_state_nxt = w_cfg_ok ? ST_RUN : ST_DONE;
      ST_RUN:   w_state_nxt = (w_all_fin || abort) ? ST_DONE : ST_RUN;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, result status and read-return bank select.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_op       <= OP_RSVD;
      r_status   <= STAT_OK;
      r_wr_first <= {WB_W{1'b0}};
      r_wr_last  <= {WB_W{1'b0}};
      r_wr_base  <= {ADDR_W{1'b0}};
      r_wr_count <= {ADDR_W{1'b0}};
      r_rd_first <= {RB_W{1'b0}};
      r_rd_last  <= {RB_W{1'b0}};
      r_rd_base  <= {ADDR_W{1'b0}};
      r_rd_count <= {ADDR_W{1'b0}};
      r_mux_sel  <= {RB_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_wr_first <= wr_bank_first;
        r_wr_last  <= wr_bank_last;
        r_wr_base  <= wr_base;
        r_wr_count <= wr_count;
        r_rd_first <= rd_bank_first;
        r_rd_last  <= rd_bank_last;
        r_rd_base  <= rd_base;
        r_rd_count <= rd_count;
      end
      // A final beat that coincides with abort still completes cleanly.
      if (w_accept) begin
        r_status <= STAT_OK;
      end else if ((r_state == ST_CHECK) && !w_cfg_ok) begin
        r_status <= STAT_INVALID;
      end else if (w_run && abort && !w_all_fin) begin
        r_status <= STAT_ABORTED;
      end else begin
        r_status <= r_status;
      end
      r_mux_sel <= w_rd_active ? w_rd_bank : {RB_W{1'b0}};
    end
  end

  // FSM / datapath outputs; an idle or finished side drives all zeros.
  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    status    = r_status;
    mux_sel   = r_mux_sel;
    if (w_wr_active) begin
      wr_we     = wr_beat;
      wr_addr   = r_wr_base + w_wr_idx;
      demux_sel = w_wr_bank;
    end else begin
      wr_we     = 1'b0;
      wr_addr   = {ADDR_W{1'b0}};
      demux_sel = {WB_W{1'b0}};
    end
    if (w_rd_active) begin
      rd_en   = 1'b1;
      rd_addr = r_rd_base + w_rd_idx;
    end else begin
      rd_en   = 1'b0;
      rd_addr = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_batch_xfer_sequencer.sv
// Directed bench for batch_xfer_sequencer: hand-computed expectations checked
// with immediate assertions, one linear stimulus sequence.
module tb_batch_xfer_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  wr_bank_first;
  logic [3:0]  wr_bank_last;
  logic [15:0] wr_base;
  logic [15:0] wr_count;
  logic [2:0]  rd_bank_first;
  logic [2:0]  rd_bank_last;
  logic [15:0] rd_base;
  logic [15:0] rd_count;
  logic        abort;
  logic        wr_beat;
  logic        wr_we;
  logic [15:0] wr_addr;
  logic [3:0]  demux_sel;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [2:0]  mux_sel;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] wrap_tab [4];

  batch_xfer_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .wr_bank_first (wr_bank_first),
    .wr_bank_last  (wr_bank_last),
    .wr_base       (wr_base),
    .wr_count      (wr_count),
    .rd_bank_first (rd_bank_first),
    .rd_bank_last  (rd_bank_last),
    .rd_base       (rd_base),
    .rd_count      (rd_count),
    .abort         (abort),
    .wr_beat       (wr_beat),
    .wr_we         (wr_we),
    .wr_addr       (wr_addr),
    .demux_sel     (demux_sel),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .mux_sel       (mux_sel),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic r, input logic b, input logic d,
                         input logic [1:0] s);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {cmd_ready, busy, done, status};
    exp = {r, b, d, s};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s {ready,busy,done,status} observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] sel,
                        input logic [15:0] addr);
    logic [20:0] obs;
    logic [20:0] exp;
    obs = {wr_we, demux_sel, wr_addr};
    exp = {we, sel, addr};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s {wr_we,demux_sel,wr_addr} observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic en, input logic [15:0] addr,
                        input logic [2:0] mux);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {rd_en, rd_addr, mux_sel};
    exp = {en, addr, mux};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s {rd_en,rd_addr,mux_sel} observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a command in IDLE, take the accept edge, return in the CHECK cycle.
  task automatic issue(input logic [1:0] op,
                       input logic [3:0] wf, input logic [3:0] wl,
                       input logic [15:0] wb, input logic [15:0] wc,
                       input logic [2:0] rf, input logic [2:0] rl,
                       input logic [15:0] rb, input logic [15:0] rc);
    cmd_op = op;
    wr_bank_first = wf; wr_bank_last = wl; wr_base = wb; wr_count = wc;
    rd_bank_first = rf; rd_bank_last = rl; rd_base = rb; rd_count = rc;
    cmd_valid = 1'b1;
    #1;
    chk_ctl("issue_ready", 1'b1, 1'b0, 1'b0, status);
    nxt();
    cmd_valid = 1'b0;
    #1;
    chk_ctl("issue_check", 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    wrap_tab[0] = 16'hFFFE; wrap_tab[1] = 16'hFFFF;
    wrap_tab[2] = 16'h0000; wrap_tab[3] = 16'h0001;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; abort = 1'b0; wr_beat = 1'b0;
    wr_bank_first = 4'd0; wr_bank_last = 4'd0; wr_base = 16'h0; wr_count = 16'h0;
    rd_bank_first = 3'd0; rd_bank_last = 3'd0; rd_base = 16'h0; rd_count = 16'h0;
    repeat (3) nxt();
    #1;
    chk_ctl("reset_ctl", 1'b1, 1'b0, 1'b0, 2'b00);
    chk_wr("reset_wr", 1'b0, 4'd0, 16'h0);
    chk_rd("reset_rd", 1'b0, 16'h0, 3'd0);
    aresetn = 1'b1;
    nxt();

    // Write banks 2..4, base 0x10, count 4, beat every cycle.
    wr_beat = 1'b1;
    issue(2'b01, 4'd2, 4'd4, 16'h0010, 16'd4, 3'd0, 3'd0, 16'h0, 16'h0);
    chk_wr("a_check_wr", 1'b0, 4'd0, 16'h0);
    for (int k = 0; k < 12; k++) begin
      nxt();
      #1;
      chk_wr("a_run_wr", 1'b1, 4'(2 + k / 4), 16'(16'h0010 + k % 4));
      chk_rd("a_run_rd_idle", 1'b0, 16'h0, 3'd0);
    end
    nxt(); #1;
    chk_ctl("a_done", 1'b0, 1'b1, 1'b1, 2'b00);
    chk_wr("a_done_wr", 1'b0, 4'd0, 16'h0);
    nxt(); #1;
    chk_ctl("a_idle", 1'b1, 1'b0, 1'b0, 2'b00);
    wr_beat = 1'b0;

    // Read banks 0..1, base 0x20, count 3; mux_sel lags by one cycle.
    issue(2'b10, 4'd0, 4'd0, 16'h0, 16'h0, 3'd0, 3'd1, 16'h0020, 16'd3);
    for (int k = 0; k < 6; k++) begin
      nxt();
      #1;
      chk_rd("b_run_rd", 1'b1, 16'(16'h0020 + k % 3), (k == 0) ? 3'd0 : 3'((k - 1) / 3));
      chk_wr("b_run_wr_idle", 1'b0, 4'd0, 16'h0);
    end
    nxt(); #1;
    chk_rd("b_done_rd", 1'b0, 16'h0, 3'd1);
    chk_ctl("b_done", 1'b0, 1'b1, 1'b1, 2'b00);
    nxt(); #1;
    chk_rd("b_idle_rd", 1'b0, 16'h0, 3'd0);
    chk_ctl("b_idle", 1'b1, 1'b0, 1'b0, 2'b00);

    // Duplex: write bank 7 count 8 at half rate, read banks 1..3 count 2.
    issue(2'b11, 4'd7, 4'd7, 16'h0100, 16'd8, 3'd1, 3'd3, 16'h0040, 16'd2);
    for (int k = 0; k < 15; k++) begin
      nxt();
      wr_beat = (k % 2 == 0);
      #1;
      chk_wr("c_wr", (k % 2 == 0), 4'd7, 16'(16'h0100 + (k + 1) / 2));
      if (k < 6) begin
        chk_rd("c_rd", 1'b1, 16'(16'h0040 + k % 2), (k == 0) ? 3'd0 : 3'(1 + (k - 1) / 2));
      end else begin
        chk_rd("c_rd_finished", 1'b0, 16'h0, (k == 6) ? 3'd3 : 3'd0);
      end
      chk_ctl("c_busy", 1'b0, 1'b1, 1'b0, 2'b00);
    end
    nxt();
    wr_beat = 1'b0;
    #1;
    chk_ctl("c_done", 1'b0, 1'b1, 1'b1, 2'b00);
    chk_wr("c_done_wr", 1'b0, 4'd0, 16'h0);
    nxt(); #1;

    // Invalid write range 5..3, cmd_valid held so the repeat waits and is taken.
    wr_beat = 1'b1;
    cmd_op = 2'b01; wr_bank_first = 4'd5; wr_bank_last = 4'd3;
    wr_base = 16'h0; wr_count = 16'd4; cmd_valid = 1'b1;
    #1;
    chk_ctl("d_accept", 1'b1, 1'b0, 1'b0, 2'b00);
    nxt(); #1;
    chk_ctl("d_check", 1'b0, 1'b1, 1'b0, 2'b00);
    chk_wr("d_check_wr", 1'b0, 4'd0, 16'h0);
    nxt(); #1;
    chk_ctl("d_done_invalid", 1'b0, 1'b1, 1'b1, 2'b01);
    chk_wr("d_done_wr", 1'b0, 4'd0, 16'h0);
    nxt(); #1;
    chk_ctl("d_idle_status_held", 1'b1, 1'b0, 1'b0, 2'b01);
    nxt();
    cmd_valid = 1'b0;
    #1;
    chk_ctl("d_held_cmd_accepted", 1'b0, 1'b1, 1'b0, 2'b00);
    nxt(); #1;
    chk_ctl("d_done_invalid2", 1'b0, 1'b1, 1'b1, 2'b01);
    nxt(); #1;
    wr_beat = 1'b0;

    // Reserved op and zero read count are both invalid.
    issue(2'b00, 4'd0, 4'd1, 16'h0, 16'd4, 3'd0, 3'd1, 16'h0, 16'd4);
    nxt(); #1;
    chk_ctl("e_op00", 1'b0, 1'b1, 1'b1, 2'b01);
    nxt(); #1;
    issue(2'b10, 4'd0, 4'd0, 16'h0, 16'h0, 3'd0, 3'd2, 16'h0, 16'd0);
    nxt(); #1;
    chk_ctl("e_rd_count0", 1'b0, 1'b1, 1'b1, 2'b01);
    chk_rd("e_rd_count0_rd", 1'b0, 16'h0, 3'd0);
    nxt(); #1;

    // Address wrap at 0xFFFE; abort in IDLE/CHECK must be ignored.
    abort = 1'b1;
    issue(2'b10, 4'd0, 4'd0, 16'h0, 16'h0, 3'd6, 3'd6, 16'hFFFE, 16'd4);
    for (int k = 0; k < 4; k++) begin
      nxt();
      abort = 1'b0;
      #1;
      chk_rd("f_wrap_rd", 1'b1, wrap_tab[k], (k == 0) ? 3'd0 : 3'd6);
    end
    nxt(); #1;
    chk_ctl("f_done_ok", 1'b0, 1'b1, 1'b1, 2'b00);
    nxt(); #1;

    // Abort at read beat 2 of 5.
    issue(2'b10, 4'd0, 4'd0, 16'h0, 16'h0, 3'd2, 3'd2, 16'h0030, 16'd5);
    for (int k = 0; k < 3; k++) begin
      nxt();
      abort = (k == 2);
      #1;
      chk_rd("g_run_rd", 1'b1, 16'(16'h0030 + k), (k == 0) ? 3'd0 : 3'd2);
    end
    nxt();
    abort = 1'b0;
    #1;
    chk_rd("g_abort_rd", 1'b0, 16'h0, 3'd2);
    chk_ctl("g_aborted", 1'b0, 1'b1, 1'b1, 2'b10);
    nxt(); #1;
    chk_ctl("g_idle_held", 1'b1, 1'b0, 1'b0, 2'b10);

    // Abort on the final beat of the last bank completes normally.
    wr_beat = 1'b1;
    issue(2'b01, 4'd0, 4'd0, 16'h0050, 16'd2, 3'd0, 3'd0, 16'h0, 16'h0);
    nxt(); #1;
    chk_wr("h_beat0", 1'b1, 4'd0, 16'h0050);
    nxt();
    abort = 1'b1;
    #1;
    chk_wr("h_beat1_abort", 1'b1, 4'd0, 16'h0051);
    nxt();
    abort = 1'b0;
    wr_beat = 1'b0;
    #1;
    chk_ctl("h_done_ok", 1'b0, 1'b1, 1'b1, 2'b00);
    nxt(); #1;

    // Reset mid-RUN drops enables with no done pulse.
    issue(2'b10, 4'd0, 4'd0, 16'h0, 16'h0, 3'd0, 3'd7, 16'h0, 16'd16);
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk_rd("i_run_rd", 1'b1, 16'(k), 3'd0);
    end
    aresetn = 1'b0;
    nxt(); #1;
    chk_rd("i_reset_rd", 1'b0, 16'h0, 3'd0);
    chk_ctl("i_reset_ctl", 1'b1, 1'b0, 1'b0, 2'b00);
    aresetn = 1'b1;
    nxt(); #1;
    chk_ctl("i_after_reset", 1'b1, 1'b0, 1'b0, 2'b00);
    nxt(); #1;
    chk_ctl("i_no_done", 1'b1, 1'b0, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
